fp_norm_pack: RTL and testbench

- Downstream neighbour of the leading-zero normalizer in the float add path.
- Consumes the normalizer's registered shift count and normalized 24-bit significand, together with the pre-normalization sign and biased exponent.
- Adjusts the exponent, classifies the result as normal, zero, overflow, underflow or special, and packs an IEEE-754 single.
- Two-stage valid/ready pipeline with backpressure.

---
 rtl/fp_norm_pack.sv | 168 ++++++++++++++++
 tb/tb_fp_norm_pack.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pack.sv
// Exponent adjust, result classification and IEEE-754 single packing behind the leading-zero normalizer.
// Optional per-result and sticky exception flags are enabled by defining FP_NORM_FLAGS_EN.
module fp_norm_pack #(
  parameter int EXP_W           = 8,
  parameter int FRAC_W          = 23,
  parameter bit FLUSH_KEEP_SIGN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [7:0]              in_num,
  input  logic [FRAC_W:0]         in_res,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef FP_NORM_FLAGS_EN
  input  logic                    flag_clr,
  output logic                    flag_ovf,
  output logic                    flag_unf,
  output logic                    flag_zero,
  output logic                    flag_bad,
  output logic [3:0]              sticky_flags,
`endif
  output logic [EXP_W+FRAC_W:0]   out_data
);

  localparam int EW = EXP_W + 2;
  localparam int W  = EXP_W + FRAC_W + 1;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  // Stage-1 registers
  logic                     s1_valid;
  logic                     s1_sign;
  logic                     s1_zero;
  logic                     s1_special;
  logic [FRAC_W-1:0]        s1_frac;
  logic signed [EW-1:0]     s1_e_adj;

  logic                     s2_adv;
  logic                     s1_adv;
  logic signed [EW-1:0]     e_adj_d;
  logic                     zero_d;
  logic [W-1:0]             out_d;
  logic                     ovf_c;
  logic                     unf_c;
  logic                     zero_c;
  logic                     unused_hidden;

  assign unused_hidden = in_res[FRAC_W];

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    e_adj_d = '0;
    zero_d  = 1'b0;
    if (in_num == 8'hFF) begin
      e_adj_d = EW'({2'b00, in_exp}) + EW'(1);
    end else if (in_num <= 8'd23) begin
      e_adj_d = EW'({2'b00, in_exp}) - EW'(in_num);
    end else begin
      zero_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; they are qualified by s1_valid and never observed while empty.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_sign    <= in_sign;
      s1_zero    <= zero_d;
      s1_special <= (in_exp == {EXP_W{1'b1}});
      s1_frac    <= in_res[FRAC_W-1:0];
      s1_e_adj   <= e_adj_d;
    end
  end

  // Priority: special, zero, overflow, underflow, normal.
  always_comb begin
    out_d  = {s1_sign, s1_e_adj[EXP_W-1:0], s1_frac};
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    zero_c = 1'b0;
    if (s1_special) begin
      out_d = {s1_sign, {EXP_W{1'b1}}, s1_frac};
    end else if (s1_zero) begin
      out_d  = '0;
      zero_c = 1'b1;
    end else if (s1_e_adj >= EXP_MAX) begin
      out_d = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_c = 1'b1;
    end else if (s1_e_adj <= EXP_ZERO) begin
      out_d = {(FLUSH_KEEP_SIGN ? s1_sign : 1'b0), {(W-1){1'b0}}};
      unf_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= out_d;
      end
    end
  end

`ifdef FP_NORM_FLAGS_EN
  logic       s1_bad;
  logic       out_xfer;
  logic [3:0] cur_flags;

  // 8'hFF is the legal right-shift code; everything above 24 is an illegal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_bad <= 1'b0;
    end else if (s1_adv && in_valid) begin
      s1_bad <= (in_num > 8'd24) && (in_num != 8'hFF);
    end
  end

  assign out_xfer  = out_valid && out_ready;
  assign cur_flags = {flag_bad, flag_zero, flag_unf, flag_ovf};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_zero <= 1'b0;
      flag_bad  <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      flag_ovf  <= ovf_c;
      flag_unf  <= unf_c;
      flag_zero <= zero_c;
      flag_bad  <= s1_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_flags <= 4'h0;
    end else if (flag_clr) begin
      sticky_flags <= out_xfer ? cur_flags : 4'h0;
    end else if (out_xfer) begin
      sticky_flags <= sticky_flags | cur_flags;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{ovf_c, unf_c, zero_c};
`endif

endmodule

// File: tb/tb_fp_norm_pack.sv
// Scoreboard bench for fp_norm_pack: two instances (flush keeps sign / flush gives +0) share stimulus.
// Flag ports are exercised when FP_NORM_FLAGS_EN is defined.
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [7:0]  in_num = '0;
  logic [23:0] in_res = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, in_ready0;
  logic        out_valid, out_valid0;
  logic [31:0] out_data, out_data0;
`ifdef FP_NORM_FLAGS_EN
  logic        flag_clr = 1'b0;
  logic        flag_ovf, flag_unf, flag_zero, flag_bad;
  logic        flag_ovf0, flag_unf0, flag_zero0, flag_bad0;
  logic [3:0]  sticky_flags, sticky_flags0;
`endif

  always #5 clk = ~clk;

  fp_norm_pack #(.EXP_W(8), .FRAC_W(23), .FLUSH_KEEP_SIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_num(in_num), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FP_NORM_FLAGS_EN
    .flag_clr(flag_clr), .flag_ovf(flag_ovf), .flag_unf(flag_unf),
    .flag_zero(flag_zero), .flag_bad(flag_bad), .sticky_flags(sticky_flags),
`endif
    .out_data(out_data)
  );

  fp_norm_pack #(.EXP_W(8), .FRAC_W(23), .FLUSH_KEEP_SIGN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_sign(in_sign), .in_exp(in_exp), .in_num(in_num), .in_res(in_res),
    .out_valid(out_valid0), .out_ready(out_ready),
`ifdef FP_NORM_FLAGS_EN
    .flag_clr(flag_clr), .flag_ovf(flag_ovf0), .flag_unf(flag_unf0),
    .flag_zero(flag_zero0), .flag_bad(flag_bad0), .sticky_flags(sticky_flags0),
`endif
    .out_data(out_data0)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d0;
    logic [3:0]  fl;
    int          cyc;
  } exp_t;

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     exact_lat = 1'b0;
  bit     rand_bp = 1'b0;
  logic   ready_force = 1'b1;
  logic        held = 1'b0;
  logic [31:0] held_data = '0;
  logic [3:0]  sticky_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: result value from plain integer arithmetic on the exponent.
  function automatic exp_t model(input logic s, input logic [7:0] e, input logic [7:0] n,
                                 input logic [23:0] r);
    exp_t x;
    int   ea;
    logic illegal;
    x.fl    = 4'h0;
    x.cyc   = 0;
    illegal = (n != 8'hFF) && (n > 8'd24);
    x.fl[3] = illegal;
    ea = (n == 8'hFF) ? int'(e) + 1 : int'(e) - int'(n);
    if (e == 8'hFF) x.d1 = {s, 8'hFF, r[22:0]};
    else if (n == 8'd24 || illegal) begin x.d1 = 32'h0; x.fl[2] = 1'b1; end
    else if (ea >= 255) begin x.d1 = {s, 8'hFF, 23'h0}; x.fl[0] = 1'b1; end
    else if (ea <= 0) begin x.d1 = {s, 31'h0}; x.fl[1] = 1'b1; end
    else x.d1 = {s, ea[7:0], r[22:0]};
    x.d0 = x.fl[1] ? 32'h0 : x.d1;
    return x;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rand_bp ? logic'($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: pops and compares on every output transfer, independent of the driver.
  always @(negedge clk) begin
    exp_t x;
    logic xf;
    if (!rst_n) begin
      sbq.delete();
      held = 1'b0;
      sticky_m = 4'h0;
    end else begin
      check("dut0_valid", {31'h0, out_valid0}, {31'h0, out_valid});
      if (held && out_valid) check("hold_stable", out_data, held_data);
      held = out_valid && !out_ready;
      held_data = out_data;
`ifdef FP_NORM_FLAGS_EN
      check("sticky", {28'h0, sticky_flags}, {28'h0, sticky_m});
`endif
      xf = out_valid && out_ready;
      x.fl = 4'h0;
      if (xf) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", out_data, 32'hDEAD_BEEF);
        end else begin
          x = sbq.pop_front();
          check("data_keep", out_data, x.d1);
          check("data_plus0", out_data0, x.d0);
`ifdef FP_NORM_FLAGS_EN
          check("flags", {28'h0, flag_bad, flag_zero, flag_unf, flag_ovf}, {28'h0, x.fl});
`endif
          if (exact_lat) check("latency", 32'(cyc - x.cyc), 32'd2);
        end
      end
`ifdef FP_NORM_FLAGS_EN
      if (flag_clr) sticky_m = xf ? x.fl : 4'h0;
      else if (xf) sticky_m = sticky_m | x.fl;
`endif
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [7:0] n, input logic [23:0] r);
    exp_t x;
    bit   ok;
    x  = model(s, e, n, r);
    ok = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_num = n; in_res = r;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        x.cyc = cyc;
        sbq.push_back(x);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    for (int w = 0; w < 200 && sbq.size() > 0; w++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sbq.size()), 32'h0);
  endtask

  initial begin
    logic [7:0] e, n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    @(posedge clk); #1;

    // Directed cases with the sink always ready.
    exact_lat = 1'b1;
    send(1'b0, 8'h7F, 8'd0,  24'hC00000);
    idle(3);
    send(1'b0, 8'h7F, 8'hFF, 24'h800000);
    send(1'b0, 8'hFE, 8'hFF, 24'h800000);
    send(1'b1, 8'h40, 8'd24, 24'h000000);
    send(1'b1, 8'h40, 8'd30, 24'h000000);
    send(1'b1, 8'h02, 8'd5,  24'h812345);
    send(1'b0, 8'hFF, 8'd0,  24'hC00001);
    send(1'b1, 8'h01, 8'd0,  24'hFFFFFF);
    send(1'b0, 8'h17, 8'd23, 24'h800000);
    send(1'b0, 8'hFE, 8'd0,  24'h800001);
    drain();
    exact_lat = 1'b0;

    // Backpressure: two accepts fill the pipe, then in_ready must stay low.
    ready_force = 1'b0;
    idle(2);
    send(1'b0, 8'h80, 8'd1, 24'h811111);
    send(1'b1, 8'h81, 8'd2, 24'h822222);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h82; in_num = 8'd3; in_res = 24'h833333;
    repeat (3) begin
      @(negedge clk);
      check("in_ready_stall", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    ready_force = 1'b1;
    send(1'b0, 8'h82, 8'd3, 24'h833333);
    send(1'b1, 8'h83, 8'd4, 24'h844444);
    drain();

    // Mid-stream reset drops both in-flight items.
    ready_force = 1'b0;
    idle(2);
    send(1'b0, 8'hFE, 8'hFF, 24'h800000);
    send(1'b1, 8'h02, 8'd5, 24'h800000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    ready_force = 1'b1;
    idle(6);

    // Random traffic with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       n = 8'hFF;
        1:       n = 8'd24;
        2:       n = 8'($urandom_range(25, 254));
        default: n = 8'($urandom_range(0, 23));
      endcase
      case ($urandom_range(0, 5))
        0:       e = 8'hFF;
        1:       e = 8'($urandom_range(0, 25));
        2:       e = 8'($urandom_range(240, 254));
        default: e = 8'($urandom_range(0, 255));
      endcase
      send(1'($urandom_range(0, 1)), e, n, 24'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    rand_bp = 1'b0;
    drain();

`ifdef FP_NORM_FLAGS_EN
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr", {28'h0, sticky_flags}, 32'h0);
`endif
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
